conv_sched_ctrl: RTL and testbench

- Sequencer for the 5x5 convolution engine over a 256x256 8-bit grayscale image held in a single-port SRAM.
- Captures the 25-coefficient stream (fc/fc_valid), then for each output pixel walks the 25 window taps. It issues SRAM reads with zero padding at image borders and accumulates products.
- Emits one clamped 8-bit pixel per out_valid pulse, in raster order.
- Sits between the top-level start/coefficient interface and the image SRAM.

---
 rtl/conv_sched_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_conv_sched_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched_ctrl.sv
// conv_sched_ctrl: sequencer for a 5x5 convolution over an IMG_W x IMG_H 8-bit
// grayscale image held in a single-port SRAM. Loads 25 signed coefficients,
// then walks each output pixel's window in raster order, zero-padding at the
// image borders, and emits one clamped 8-bit result per out_valid pulse.
// Optional feature: define CONV_ABS_EN to emit min(|acc|, 255) (edge magnitude)
// instead of clamping negative sums to 0. Timing and ports are unchanged.
module conv_sched_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fc_valid,
  input  logic signed [7:0] fc,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_rdata,
  output logic [7:0]        out_pixel,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int NTAPS = 25;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_DRAIN, S_EMIT, S_DONE} state_t;

  // One window tap: whether it lies inside the image, and its SRAM address.
  typedef struct packed {
    logic              ok;
    logic [ADDR_W-1:0] addr;
  } tap_req_t;

  state_t                  state;
  logic signed [7:0]       coef [NTAPS];
  logic [4:0]              k;          // coefficients captured so far
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic [4:0]              tap;        // 0..24, row-major within the window
  logic [2:0]              tap_m;      // window row 0..4 (offset +2)
  logic [2:0]              tap_n;      // window column 0..4 (offset +2)
  logic [4:0]              tap_d;      // tap whose read data arrives this cycle
  logic                    pad_d;      // that tap was outside the image
  logic                    mac_en;     // accumulate this cycle
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [16:0]      coef_ext;
  logic signed [16:0]      pix_ext;
  logic signed [16:0]      product;
  logic                    last_col;
  logic                    last_row;
  logic [COL_W-1:0]        next_col;
  logic [ROW_W-1:0]        next_row;
  logic [2:0]              nxt_m;
  logic [2:0]              nxt_n;
  tap_req_t                req_first;
  tap_req_t                req_next;
  tap_req_t                req_pixel;

  // Map (pixel row/col, window offset) to an in-bounds flag and an address.
  function automatic tap_req_t lookup(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c,
                                      input logic [2:0] m, input logic [2:0] n);
    int       y;
    int       x;
    tap_req_t q;
    y      = int'(r) + int'(m) - 2;
    x      = int'(c) + int'(n) - 2;
    q.ok   = (y >= 0) && (y < IMG_H) && (x >= 0) && (x < IMG_W);
    q.addr = ADDR_W'(y * IMG_W + x);
    return q;
  endfunction

  // Saturate the accumulator to an 8-bit pixel.
  function automatic logic [7:0] clamp_pix(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] v;
`ifdef CONV_ABS_EN
    v = a[ACC_W-1] ? -a : a;
`else
    v = a[ACC_W-1] ? '0 : a;
`endif
    return (v > PIX_MAX) ? 8'hFF : v[7:0];
  endfunction

  // Raster position and window-walk lookahead.
  assign last_col  = (col == COL_W'(IMG_W - 1));
  assign last_row  = (row == ROW_W'(IMG_H - 1));
  assign next_col  = last_col ? '0 : col + 1'b1;
  assign next_row  = last_col ? row + 1'b1 : row;
  assign nxt_n     = (tap_n == 3'd4) ? 3'd0 : tap_n + 3'd1;
  assign nxt_m     = (tap_n == 3'd4) ? tap_m + 3'd1 : tap_m;
  assign req_first = lookup(ROW_W'(0), COL_W'(0), 3'd0, 3'd0);
  assign req_next  = lookup(row, col, nxt_m, nxt_n);
  assign req_pixel = lookup(next_row, next_col, 3'd0, 3'd0);

  // Multiply-accumulate for the tap whose read data is on sram_rdata now.
  // NOTE: every signal here is assigned on every pass, so no latch is inferred.
  always_comb begin
    coef_ext = {{9{coef[tap_d][7]}}, coef[tap_d]};
    pix_ext  = {9'd0, (pad_d ? 8'd0 : sram_rdata)};
    product  = coef_ext * pix_ext;
    acc_next = mac_en ? acc + {{(ACC_W-17){product[16]}}, product} : acc;
  end

  // Control FSM with registered outputs, read pipeline and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      row       <= '0;
      col       <= '0;
      tap       <= '0;
      tap_m     <= '0;
      tap_n     <= '0;
      tap_d     <= '0;
      pad_d     <= 1'b0;
      mac_en    <= 1'b0;
      acc       <= '0;
      // NOTE: the 25 coefficients are plain flops, so they take the reset too;
      // a RAM-based store would not be reset this way.
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
      sram_rd   <= 1'b0;
      sram_addr <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: these defaults are non-blocking; a later assignment to the same
      // register within this block takes precedence.
      out_valid <= 1'b0;
      sram_rd   <= 1'b0;
      mac_en    <= 1'b0;
      acc       <= acc_next;
      tap_d     <= tap;
      pad_d     <= ~sram_rd;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (fc_valid) begin
            coef[k] <= fc;
            k       <= k + 1'b1;
            if (k == 5'd24) begin
              state   <= S_FETCH;
              row     <= '0;
              col     <= '0;
              acc     <= '0;
              tap     <= '0;
              tap_m   <= '0;
              tap_n   <= '0;
              sram_rd <= req_first.ok;
              if (req_first.ok) sram_addr <= req_first.addr;
            end
          end
        end
        S_FETCH: begin
          if (!start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            mac_en <= 1'b1;
            if (tap == 5'd24) begin
              state <= S_DRAIN;
            end else begin
              tap     <= tap + 1'b1;
              tap_m   <= nxt_m;
              tap_n   <= nxt_n;
              sram_rd <= req_next.ok;
              if (req_next.ok) sram_addr <= req_next.addr;
            end
          end
        end
        S_DRAIN: begin
          if (!start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= S_EMIT;
            out_pixel <= clamp_pix(acc_next);
            out_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          acc <= '0;
          col <= next_col;
          row <= next_row;
          if (!start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (last_col && last_row) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= S_FETCH;
            tap     <= '0;
            tap_m   <= '0;
            tap_n   <= '0;
            sram_rd <= req_pixel.ok;
            if (req_pixel.ok) sram_addr <= req_pixel.addr;
          end
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Testbench for conv_sched_ctrl on a reduced 16x16 image. A behavioural SRAM
// returns random junk when not read; expected pixels come from a direct
// window-sum model with zero padding and the output saturation rule.
module tb_conv_sched_ctrl;

  localparam int W    = 16;
  localparam int H    = 16;
  localparam int AW   = 8;
  localparam int AC   = 21;
  localparam int NPIX = W * H;
`ifdef CONV_ABS_EN
  localparam logic [7:0] IMPULSE_NEIGHBOUR = 8'd10;
`else
  localparam logic [7:0] IMPULSE_NEIGHBOUR = 8'd0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              fc_valid = 1'b0;
  logic signed [7:0] fc = '0;
  logic              sram_rd;
  logic [AW-1:0]     sram_addr;
  logic [7:0]        sram_rdata = '0;
  logic [7:0]        out_pixel;
  logic              out_valid;
  logic              busy;
  logic              done;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [7:0]  img [NPIX];
  int          coef_m [25];
  logic [7:0]  got_pix [$];
  int          got_cyc [$];
  int          got_count;
  int          fetch_cyc;
  bit          done_seen;
  bit          trace_rd [25];
  int          trace_addr [25];

  conv_sched_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .ACC_W(AC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fc_valid   (fc_valid),
    .fc         (fc),
    .sram_rd    (sram_rd),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port SRAM: data one cycle after a read, junk otherwise.
  always @(posedge clk) sram_rdata <= sram_rd ? img[sram_addr] : 8'($urandom);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required run to finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pixel: sum over the 5x5 window, outside taps contribute zero.
  function automatic logic [7:0] ref_pixel(input int r, input int c);
    int s = 0;
    for (int dy = -2; dy <= 2; dy++) begin
      for (int dx = -2; dx <= 2; dx++) begin
        int y = r + dy;
        int x = c + dx;
        if (y >= 0 && y < H && x >= 0 && x < W)
          s += coef_m[(dy + 2) * 5 + dx + 2] * int'(img[y * W + x]);
      end
    end
`ifdef CONV_ABS_EN
    if (s < 0) s = -s;
`else
    if (s < 0) s = 0;
`endif
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  task automatic set_laplacian();
    for (int i = 0; i < 25; i++) coef_m[i] = -1;
    coef_m[12] = 24;
  endtask

  task automatic set_random();
    for (int i = 0; i < 25; i++) coef_m[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
  endtask

  // Start a run, load the coefficients (gap idle cycles between strobes),
  // then collect pulses until done, or until max_pix pulses and abort.
  task automatic run_image(input int gap, input bit extra, input int max_pix, input bit hit_rst);
    int budget;
    int target;
    bit stop;
    got_pix.delete();
    got_cyc.delete();
    done_seen = 1'b0;
    stop      = 1'b0;
    start     = 1'b1;
    fc_valid  = 1'b0;
    step();
    for (int k = 0; k < 25; k++) begin
      if (k > 0) repeat (gap) step();
      fc       = 8'(coef_m[k]);
      fc_valid = 1'b1;
      step();
      fc_valid = 1'b0;
    end
    fetch_cyc = cyc;
    budget    = NPIX * 27 + 50;
    for (int i = 0; i < budget && !stop; i++) begin
      if (i < 25) begin
        trace_rd[i]   = sram_rd;
        trace_addr[i] = int'(sram_addr);
      end
      if (out_valid) begin
        got_pix.push_back(out_pixel);
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_seen = 1'b1;
        stop      = 1'b1;
      end else if (max_pix > 0 && got_pix.size() >= max_pix) begin
        stop = 1'b1;
        if (hit_rst) begin
          repeat (5) step();
          rst = 1'b1;
          step();
          rst = 1'b0;
        end
        start = 1'b0;
      end else begin
        fc_valid = extra && (i == 3 || i == 9);
        fc       = 8'($urandom);
        step();
      end
    end
    fc_valid  = 1'b0;
    got_count = got_pix.size();
    target    = (max_pix > 0) ? max_pix : NPIX;
    while (got_pix.size() < target) begin
      got_pix.push_back('x);
      got_cyc.push_back(-1000);
    end
    if (max_pix == 0) begin
      vectors++;
      if (done_seen !== 1'b1) begin
        miscompares++;
        $display("FAIL run_done: done not seen within %0d cycles, required 1", budget);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++;
    if ({sram_rd, sram_addr, out_pixel, out_valid, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd=%0b addr=%0d pix=%0d ov=%0b busy=%0b done=%0b, required all 0",
               sram_rd, sram_addr, out_pixel, out_valid, busy, done);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_laplacian_const();
    for (int i = 0; i < NPIX; i++) img[i] = 8'd100;
    set_laplacian();
    run_image(0, 1'b0, 0, 1'b0);
    vectors++;
    if (got_count !== NPIX) begin
      miscompares++;
      $display("FAIL pulse_count: got %0d, required %0d", got_count, NPIX);
    end
    vectors++;
    if ((got_cyc[0] - fetch_cyc) !== 26) begin
      miscompares++;
      $display("FAIL first_latency: got %0d, required 26", got_cyc[0] - fetch_cyc);
    end
    for (int i = 1; i < NPIX; i++) begin
      vectors++;
      if ((got_cyc[i] - got_cyc[i-1]) !== 27) begin
        miscompares++;
        $display("FAIL pixel_period[%0d]: got %0d, required 27", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
    for (int i = 0; i < NPIX; i++) begin
      vectors++;
      if (got_pix[i] !== ref_pixel(i / W, i % W)) begin
        miscompares++;
        $display("FAIL lap_pixel(%0d,%0d): got %0d, required %0d", i / W, i % W, got_pix[i],
                 ref_pixel(i / W, i % W));
      end
    end
    vectors++;
    if (got_pix[10 * W + 10] !== 8'd0) begin
      miscompares++;
      $display("FAIL lap_interior: got %0d, required 0", got_pix[10 * W + 10]);
    end
    vectors++;
    if (got_pix[0] !== 8'd255) begin
      miscompares++;
      $display("FAIL lap_corner: got %0d, required 255", got_pix[0]);
    end
    vectors++;
    if (got_pix[10] !== 8'd255) begin
      miscompares++;
      $display("FAIL lap_top_edge: got %0d, required 255", got_pix[10]);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_state: done=%0b busy=%0b, required 1 0", done, busy);
    end
    start = 1'b0;
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL return_idle: done=%0b busy=%0b, required 0 0", done, busy);
    end
  endtask

  task automatic test_address_trace();
    set_random();
    run_image(0, 1'b0, 1, 1'b0);
    step();
    for (int t = 0; t < 25; t++) begin
      int  m      = t / 5 - 2;
      int  n      = t % 5 - 2;
      bit  exp_rd = (m >= 0) && (n >= 0);
      vectors++;
      if (trace_rd[t] !== exp_rd) begin
        miscompares++;
        $display("FAIL trace_rd[t=%0d]: got %0b, required %0b", t, trace_rd[t], exp_rd);
      end
      if (exp_rd) begin
        vectors++;
        if (trace_addr[t] !== m * W + n) begin
          miscompares++;
          $display("FAIL trace_addr[t=%0d]: got %0d, required %0d", t, trace_addr[t], m * W + n);
        end
      end
    end
    vectors++;
    if (got_pix[0] !== ref_pixel(0, 0)) begin
      miscompares++;
      $display("FAIL trace_pixel0: got %0d, required %0d", got_pix[0], ref_pixel(0, 0));
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_idle[%0d]: ov=%0b busy=%0b, required 0 0", i, out_valid, busy);
      end
      step();
    end
  endtask

  task automatic test_gapped_load();
    logic [7:0] ref_q [$];
    set_random();
    run_image(0, 1'b0, 0, 1'b0);
    ref_q = got_pix;
    start = 1'b0;
    step();
    for (int i = 0; i < NPIX; i++) begin
      vectors++;
      if (ref_q[i] !== ref_pixel(i / W, i % W)) begin
        miscompares++;
        $display("FAIL rand_pixel(%0d,%0d): got %0d, required %0d", i / W, i % W, ref_q[i],
                 ref_pixel(i / W, i % W));
      end
    end
    run_image(3, 1'b1, 0, 1'b0);
    start = 1'b0;
    step();
    for (int i = 0; i < NPIX; i++) begin
      vectors++;
      if (got_pix[i] !== ref_q[i]) begin
        miscompares++;
        $display("FAIL gapped_vs_b2b(%0d,%0d): got %0d, required %0d", i / W, i % W, got_pix[i],
                 ref_q[i]);
      end
    end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
    img[5 * W + 5] = 8'd10;
    set_laplacian();
    run_image(0, 1'b0, 5 * W + 7, 1'b0);
    step();
    vectors++;
    if (got_pix[5 * W + 5] !== 8'd240) begin
      miscompares++;
      $display("FAIL impulse_centre: got %0d, required 240", got_pix[5 * W + 5]);
    end
    vectors++;
    if (got_pix[5 * W + 6] !== IMPULSE_NEIGHBOUR) begin
      miscompares++;
      $display("FAIL impulse_neighbour: got %0d, required %0d", got_pix[5 * W + 6], IMPULSE_NEIGHBOUR);
    end
    for (int i = 0; i < 5 * W + 7; i++) begin
      vectors++;
      if (got_pix[i] !== ref_pixel(i / W, i % W)) begin
        miscompares++;
        $display("FAIL impulse_pixel(%0d,%0d): got %0d, required %0d", i / W, i % W, got_pix[i],
                 ref_pixel(i / W, i % W));
      end
    end
  endtask

  task automatic test_mid_reset();
    set_random();
    run_image(0, 1'b0, 10, 1'b1);
    vectors++;
    if ({sram_rd, sram_addr, out_pixel, out_valid, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: rd=%0b addr=%0d pix=%0d ov=%0b busy=%0b done=%0b, required all 0",
               sram_rd, sram_addr, out_pixel, out_valid, busy, done);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet[%0d]: ov=%0b busy=%0b, required 0 0", i, out_valid, busy);
      end
    end
    run_image(0, 1'b0, 1, 1'b0);
    step();
    vectors++;
    if (got_pix[0] !== ref_pixel(0, 0)) begin
      miscompares++;
      $display("FAIL restart_pixel0: got %0d, required %0d", got_pix[0], ref_pixel(0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_laplacian_const();
    test_address_trace();
    test_gapped_load();
    test_impulse();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
